// File: rtl/pip_fetchbuf_pkg.sv
// Shared types and constants for the fetch-group buffer between the IFU and decode.
package pip_fetchbuf_pkg;

  localparam int unsigned PKG_XLEN = 64;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned GROUP_WORDS = 4;

  // One IFU fetch group: four instruction words, PC of word 0, per-word valid mask, fault type.
  typedef struct packed {
    logic [127:0]          instr;
    logic [PKG_XLEN-1:0]   grouppc;
    logic [GROUP_WORDS-1:0] mask;
    logic [5:0]            errtype;
  } fetch_group_t;

endpackage

// File: rtl/pip_group_fifo.sv
// Circular FIFO of fetch groups with a head-entry mask rewrite port.
module pip_group_fifo
  import pip_fetchbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_group_t               push_data,
  input  logic                       pop,
  input  logic                       head_wr,
  input  logic [GROUP_WORDS-1:0]     head_mask,
  output fetch_group_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_group_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;

  // Pointer/count bookkeeping; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; a pop wins over a head mask rewrite on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush) begin
      if (push) mem[wr_ptr] <= push_data;
      if (head_wr && !pop) mem[rd_ptr].mask <= head_mask;
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/pip_fetch_buffer.sv
// Buffers IFU fetch groups and issues one instruction per cycle, with PC, to decode.
module pip_fetch_buffer
  import pip_fetchbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = PKG_XLEN
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            flush_i,
  input  logic [127:0]    ifu_instr_i,
  input  logic [XLEN-1:0] ifu_grouppc_i,
  input  logic [3:0]      ifu_validword_i,
  input  logic [5:0]      ifu_errtype_i,
  input  logic            ifu_valid_i,
  output logic            ifu_ready_o,
  output logic [31:0]     dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [5:0]      dec_errtype_o,
  output logic            dec_valid_o,
  input  logic            dec_ready_i
);

  fetch_group_t           push_data;
  fetch_group_t           head;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   head_wr;
  logic                   fire;
  logic [1:0]             word_idx;
  logic [3:0]             mask_next;
  logic [XLEN-1:0]        word_pc;
  logic                   faulted;

  assign push_data = '{instr:   ifu_instr_i,
                       grouppc: ifu_grouppc_i,
                       mask:    ifu_validword_i,
                       errtype: ifu_errtype_i};

  // Empty groups (no words, no fault) complete the handshake but are never stored.
  assign push = ifu_valid_i & ifu_ready_o & ~flush_i &
                ((ifu_validword_i != '0) | (ifu_errtype_i != '0));

  pip_group_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (arst_i),
    .flush     (flush_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_wr   (head_wr),
    .head_mask (mask_next),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign dec_valid_o = (count != '0);
  assign ifu_ready_o = ~full;
  assign fire        = ~empty & dec_ready_i & ~flush_i;
  assign faulted     = (head.errtype != '0);

  // Lowest set bit of the head mask; an empty mask selects word 0.
  always_comb begin
    word_idx = '0;
    for (int unsigned i = GROUP_WORDS; i > 0; i--) begin
      if (head.mask[i-1]) word_idx = 2'(i - 1);
    end
  end

  assign word_pc   = head.grouppc + XLEN'(word_idx) * XLEN'(WORD_BYTES);
  assign mask_next = head.mask & ~(4'b0001 << word_idx);

  // Decode-side presentation, held at zero while nothing is buffered.
  always_comb begin
    dec_instr_o   = '0;
    dec_pc_o      = '0;
    dec_errtype_o = '0;
    if (dec_valid_o) begin
      dec_pc_o      = word_pc;
      dec_errtype_o = head.errtype;
      if (!faulted) dec_instr_o = head.instr[32*word_idx +: 32];
    end
  end

  // Retire the issued word: faulted groups and last words pop, others rewrite the mask.
  always_comb begin
    pop     = 1'b0;
    head_wr = 1'b0;
    if (fire) begin
      if (faulted || mask_next == '0) pop = 1'b1;
      else                            head_wr = 1'b1;
    end
  end

endmodule
